// File: rtl/mydesign_round_ctrl.sv
// Round sequencer around the combinational mydesign datapath: walks every (i, j)
// pair of the accepted index range, one per clock, and accumulates the F results.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for an operand set; in_ready high
// RUN   | one round per cycle, summing dp_f and stepping (i, j)
// DONE  | result presented on out_*; waiting for out_ready
module mydesign_round_ctrl #(
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    input  logic [7:0]       in_c,
    input  logic [2:0]       in_imax,
    input  logic [2:0]       in_jmax,
    output logic [7:0]       dp_a,
    output logic [7:0]       dp_b,
    output logic [7:0]       dp_c,
    output logic [2:0]       dp_i,
    output logic [2:0]       dp_j,
    input  logic [15:0]      dp_f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [6:0]       out_rounds,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    logic [2:0] imax;
    logic [2:0] jmax;
    logic [ACC_W:0] acc_next;

    // One spare bit on top of the accumulator catches the carry for saturation.
    assign acc_next = {1'b0, out_sum} + {{(ACC_W - 15){1'b0}}, dp_f};
    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            dp_a       <= '0;
            dp_b       <= '0;
            dp_c       <= '0;
            dp_i       <= '0;
            dp_j       <= '0;
            imax       <= '0;
            jmax       <= '0;
            out_sum    <= '0;
            out_rounds <= '0;
            out_ovf    <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dp_a       <= in_a;
                        dp_b       <= in_b;
                        dp_c       <= in_c;
                        imax       <= in_imax;
                        jmax       <= in_jmax;
                        dp_i       <= '0;
                        dp_j       <= '0;
                        out_sum    <= '0;
                        out_rounds <= '0;
                        out_ovf    <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // Once saturated, the sum stays pinned for the rest of the operation.
                    if (out_ovf || acc_next[ACC_W]) begin
                        out_sum <= '1;
                        out_ovf <= 1'b1;
                    end else begin
                        out_sum <= acc_next[ACC_W-1:0];
                    end
                    out_rounds <= out_rounds + 7'd1;
                    if (dp_j == jmax) begin
                        dp_j <= '0;
                        if (dp_i == imax) begin
                            dp_i      <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            dp_i <= dp_i + 3'd1;
                        end
                    end else begin
                        dp_j <= dp_j + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mydesign_round_ctrl.sv
// Directed bench for mydesign_round_ctrl: default-width instance with a switchable
// dp_f stub, plus a 16-bit accumulator instance for the saturation case.
module tb_mydesign_round_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_valid2;
    logic        in_ready, in_ready2;
    logic [7:0]  in_a, in_b, in_c;
    logic [2:0]  in_imax, in_jmax;
    logic [7:0]  dp_a, dp_b, dp_c, dp_a2, dp_b2, dp_c2;
    logic [2:0]  dp_i, dp_j, dp_i2, dp_j2;
    logic [15:0] dp_f, dp_f2;
    logic        out_valid, out_valid2;
    logic        out_ready, out_ready2;
    logic [23:0] out_sum;
    logic [15:0] out_sum2;
    logic [6:0]  out_rounds, out_rounds2;
    logic        out_ovf, out_ovf2;

    int          checks = 0;
    int          failures = 0;
    int          stub_mode = 0;
    logic [15:0] stub_val = 16'h0;

    always #5 clk = ~clk;

    // dp_f stub: constant, {i,j} index tag, or operand C
    always_comb begin
        dp_f = stub_val;
        case (stub_mode)
            1: dp_f = {10'b0, dp_i, dp_j};
            2: dp_f = {8'b0, dp_c};
            default: dp_f = stub_val;
        endcase
    end
    assign dp_f2 = 16'hFFFF;

    mydesign_round_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_imax(in_imax), .in_jmax(in_jmax),
        .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_i(dp_i), .dp_j(dp_j), .dp_f(dp_f),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_rounds(out_rounds), .out_ovf(out_ovf)
    );

    mydesign_round_ctrl #(.ACC_W(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_imax(in_imax), .in_jmax(in_jmax),
        .dp_a(dp_a2), .dp_b(dp_b2), .dp_c(dp_c2), .dp_i(dp_i2), .dp_j(dp_j2), .dp_f(dp_f2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_sum(out_sum2),
        .out_rounds(out_rounds2), .out_ovf(out_ovf2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] a, b, c, input logic [2:0] imax, jmax);
        in_a = a; in_b = b; in_c = c; in_imax = imax; in_jmax = jmax;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Edges from the accept edge until out_valid is seen; expected to be N.
    task automatic wait_done(input string tag, input int exp_n);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!out_valid && n < 200);
        check_val(tag, n, exp_n);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0;
        out_ready = 1'b0; out_ready2 = 1'b0;
        in_a = 8'h0; in_b = 8'h0; in_c = 8'h0; in_imax = 3'd0; in_jmax = 3'd0;
        tick(); tick();
        rst = 1'b0;
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_sum", out_sum, 0);
        check_val("rst_rounds", out_rounds, 0);
        check_val("rst_ovf", out_ovf, 0);
        check_val("rst_dp", {dp_a, dp_i, dp_j}, 0);

        // single round
        stub_mode = 0; stub_val = 16'h0024;
        start_op(8'h06, 8'h06, 8'h06, 3'd0, 3'd0);
        check_val("single_dp_abc", {dp_a, dp_b, dp_c}, 24'h060606);
        check_val("single_in_ready_run", in_ready, 0);
        check_val("single_valid_run", out_valid, 0);
        wait_done("single_latency", 1);
        check_val("single_sum", out_sum, 24'h000024);
        check_val("single_rounds", out_rounds, 1);
        check_val("single_ovf", out_ovf, 0);
        handshake();
        check_val("single_idle_ready", in_ready, 1);
        check_val("single_idle_valid", out_valid, 0);
        check_val("single_idle_sum_held", out_sum, 24'h000024);

        // full 8x8 sweep, ordering checked every cycle
        stub_mode = 1;
        start_op(8'h01, 8'h02, 8'h03, 3'd7, 3'd7);
        for (int k = 0; k < 64; k++) begin
            check_val("sweep_order", {dp_i, dp_j}, k);
            if (k < 63) check_val("sweep_valid_low", out_valid, 0);
            tick();
        end
        check_val("sweep_valid", out_valid, 1);
        check_val("sweep_sum", out_sum, 2016);
        check_val("sweep_rounds", out_rounds, 64);
        check_val("sweep_dp_done", {dp_i, dp_j}, 0);
        handshake();

        // backpressure, and in_valid ignored until the handshake lands
        stub_mode = 0; stub_val = 16'hFFFF;
        start_op(8'h11, 8'h22, 8'h33, 3'd1, 3'd2);
        wait_done("bp_latency", 6);
        in_a = 8'h55; in_imax = 3'd0; in_jmax = 3'd0; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_val("bp_sum_stable", out_sum, 24'h05FFFA);
            check_val("bp_in_ready_low", in_ready, 0);
            check_val("bp_valid_held", out_valid, 1);
            tick();
        end
        check_val("bp_rounds", out_rounds, 6);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("bp_idle_ready", in_ready, 1);
        check_val("bp_new_ignored", dp_a, 8'h11);
        tick();
        in_valid = 1'b0;
        check_val("bp_new_accepted", dp_a, 8'h55);
        check_val("bp_new_busy", in_ready, 0);
        wait_done("bp_second_latency", 1);
        check_val("bp_second_sum", out_sum, 24'h00FFFF);
        check_val("bp_second_rounds", out_rounds, 1);
        handshake();

        // saturation on the 16-bit instance
        in_imax = 3'd0; in_jmax = 3'd1; in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        tick();
        check_val("sat_first_sum", out_sum2, 16'hFFFF);
        check_val("sat_first_ovf", out_ovf2, 0);
        tick();
        check_val("sat_valid", out_valid2, 1);
        check_val("sat_sum", out_sum2, 16'hFFFF);
        check_val("sat_ovf", out_ovf2, 1);
        check_val("sat_rounds", out_rounds2, 2);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        in_jmax = 3'd0; in_valid2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        tick();
        check_val("sat_cleared_ovf", out_ovf2, 0);
        check_val("sat_cleared_rounds", out_rounds2, 1);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;

        // reset in the middle of a run
        stub_mode = 1;
        start_op(8'h0A, 8'h0B, 8'h0C, 3'd7, 3'd7);
        for (int k = 0; k < 10; k++) tick();
        check_val("mid_rounds", out_rounds, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("mid_rst_ready", in_ready, 1);
        check_val("mid_rst_valid", out_valid, 0);
        check_val("mid_rst_sum", out_sum, 0);
        check_val("mid_rst_dp", {dp_i, dp_j}, 0);
        for (int k = 0; k < 70; k++) begin
            if (out_valid) check_val("mid_rst_no_valid", out_valid, 0);
            tick();
        end
        stub_mode = 0; stub_val = 16'h0001;
        start_op(8'h00, 8'h00, 8'h00, 3'd0, 3'd0);
        wait_done("mid_after_latency", 1);
        check_val("mid_after_sum", out_sum, 1);
        handshake();

        // back-to-back with out_ready tied high, dp_f = C
        stub_mode = 2; out_ready = 1'b1;
        in_a = 8'h01; in_b = 8'h02; in_c = 8'h03; in_imax = 3'd0; in_jmax = 3'd1;
        in_valid = 1'b1;
        tick();
        in_c = 8'h09; in_imax = 3'd1; in_jmax = 3'd0;
        tick();
        check_val("b2b_first_running", out_valid, 0);
        tick();
        check_val("b2b_first_valid", out_valid, 1);
        check_val("b2b_first_sum", out_sum, 6);
        check_val("b2b_first_rounds", out_rounds, 2);
        tick();
        check_val("b2b_idle_ready", in_ready, 1);
        check_val("b2b_idle_valid", out_valid, 0);
        tick();
        in_valid = 1'b0;
        check_val("b2b_second_accept", dp_c, 8'h09);
        check_val("b2b_second_cleared", out_sum, 0);
        wait_done("b2b_second_latency", 2);
        check_val("b2b_second_sum", out_sum, 18);
        check_val("b2b_second_rounds", out_rounds, 2);
        check_val("b2b_second_ovf", out_ovf, 0);
        tick();
        out_ready = 1'b0;
        check_val("b2b_end_ready", in_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
